// File: rtl/awgn_run_ctrl.sv
// rtl/awgn_run_ctrl.sv - Box-Muller AWGN generator run controller: seeds, sequencing, sample FIFO
module awgn_run_ctrl #(
    parameter int W          = 16,
    parameter int PIPE_LAT   = 4,
    parameter int RST_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  num_samples,
    input  logic         seed_we,
    input  logic [2:0]   seed_sel,
    input  logic [31:0]  seed_in,
    output logic         gen_reset,
    output logic [31:0]  s1,
    output logic [31:0]  s2,
    output logic [31:0]  s3,
    output logic [31:0]  s4,
    output logic [31:0]  s5,
    output logic [31:0]  s6,
    input  logic [W-1:0] gen_x0,
    input  logic [W-1:0] gen_x1,
    output logic [W-1:0] out_x0,
    output logic [W-1:0] out_x1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [15:0]  overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] FILL_LOAD = 16'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [15:0]   nsamp_q;
    logic [31:0]   seed [6];

    logic [2*W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    fill, fill_nxt;
    logic           full, push_req, push, pop, drop;
    logic [2*W-1:0] head;

    // The generator cannot be stalled: a full FIFO only accepts a pair if the head leaves this cycle
    assign full      = (fill == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign push_req  = (state == S_RUN);
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign fill_nxt  = fill + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign head   = mem[rd_ptr];
    assign out_x0 = out_valid ? head[W-1:0]   : '0;
    assign out_x1 = out_valid ? head[2*W-1:W] : '0;

    assign s1 = seed[0];
    assign s2 = seed[1];
    assign s3 = seed[2];
    assign s4 = seed[3];
    assign s5 = seed[4];
    assign s6 = seed[5];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gen_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_samples != 16'd0) begin
                        state_nxt = S_LOAD;
                        cnt_nxt   = RST_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (cnt == 16'd0) begin
                    state_nxt = S_FILL;
                    cnt_nxt   = FILL_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_FILL: begin
                busy      = 1'b1;
                gen_reset = 1'b0;
                if (cnt == 16'd0) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = nsamp_q - 16'd1;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                gen_reset = 1'b0;
                if (cnt == 16'd0) state_nxt = S_DRAIN;
                else              cnt_nxt   = cnt - 16'd1;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave as the last pair is popped so done follows without an idle cycle
                if (fill_nxt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            nsamp_q      <= '0;
            overflow_cnt <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            seed[0]      <= 32'hFFFF_FFFF;
            seed[1]      <= 32'hFDFD_FDFD;
            seed[2]      <= 32'hEFEF_EFEF;
            seed[3]      <= 32'hFEDA_FEDA;
            seed[4]      <= 32'hFFFA_FFFA;
            seed[5]      <= 32'hFDEA_FDEA;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fill  <= fill_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (state == S_IDLE && seed_we && seed_sel <= 3'd5)
                seed[seed_sel] <= seed_in;
            if (state == S_IDLE && start && num_samples != 16'd0) begin
                nsamp_q      <= num_samples;
                overflow_cnt <= '0;
            end else if (drop && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {gen_x1, gen_x0};
    end
endmodule

// File: tb/tb_awgn_run_ctrl.sv
// tb/tb_awgn_run_ctrl.sv - directed self-checking bench for awgn_run_ctrl
module tb_awgn_run_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, seed_we, gen_reset, out_valid, out_ready, busy, done;
    logic [15:0] num_samples, overflow_cnt;
    logic [2:0]  seed_sel;
    logic [31:0] seed_in, s1, s2, s3, s4, s5, s6;
    logic [15:0] gen_x0, gen_x1, out_x0, out_x1;
    int          errors = 0;
    int          checks = 0;

    always #10 clk = ~clk;

    awgn_run_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
        .seed_we(seed_we), .seed_sel(seed_sel), .seed_in(seed_in),
        .gen_reset(gen_reset), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6),
        .gen_x0(gen_x0), .gen_x1(gen_x1), .out_x0(out_x0), .out_x1(out_x1),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .overflow_cnt(overflow_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gen(input int c);
        gen_x0 = 16'hA000 + 16'(c);
        gen_x1 = 16'h5000 + 16'(c);
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_s1"}, s1, 32'hFFFFFFFF);
        chk({tag, "_s2"}, s2, 32'hFDFDFDFD);
        chk({tag, "_s3"}, s3, 32'hEFEFEFEF);
        chk({tag, "_s4"}, s4, 32'hFEDAFEDA);
        chk({tag, "_s5"}, s5, 32'hFFFAFFFA);
        chk({tag, "_s6"}, s6, 32'hFDEAFDEA);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_samples = '0; seed_we = 1'b0;
        seed_sel = '0; seed_in = '0; out_ready = 1'b1;
        set_gen(0);
        step(); step();
        chk_defaults("rst");
        chk("rst_gen_reset", 32'(gen_reset), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        chk("rst_out_x0", 32'(out_x0), 32'd0);
        reset = 1'b0;
        step();

        // Normal run: 8 pairs, consumer always ready
        start = 1'b1; num_samples = 16'd8; set_gen(0);
        for (int c = 1; c <= 17; c++) begin
            step();
            start = 1'b0;
            set_gen(c);
            chk($sformatf("run8_gen_reset_c%0d", c), 32'(gen_reset),
                (c >= 3 && c <= 14) ? 32'd0 : 32'd1);
            chk($sformatf("run8_busy_c%0d", c), 32'(busy), (c <= 15) ? 32'd1 : 32'd0);
            chk($sformatf("run8_done_c%0d", c), 32'(done), (c == 16) ? 32'd1 : 32'd0);
            chk($sformatf("run8_valid_c%0d", c), 32'(out_valid),
                (c >= 8 && c <= 15) ? 32'd1 : 32'd0);
            if (c >= 8 && c <= 15) begin
                chk($sformatf("run8_x0_c%0d", c), 32'(out_x0), 32'(16'hA000 + 16'(c - 1)));
                chk($sformatf("run8_x1_c%0d", c), 32'(out_x1), 32'(16'h5000 + 16'(c - 1)));
            end
        end
        chk("run8_ovf", 32'(overflow_cnt), 32'd0);

        // Overflow run: 10 pairs with consumer stalled, 4 kept, 6 dropped
        out_ready = 1'b0;
        start = 1'b1; num_samples = 16'd10; set_gen(0);
        for (int c = 1; c <= 16; c++) begin
            step();
            start = 1'b0;
            set_gen(c);
        end
        step();
        set_gen(17);
        chk("ovf_count", 32'(overflow_cnt), 32'd6);
        chk("ovf_busy_drain", 32'(busy), 32'd1);
        chk("ovf_gen_reset_drain", 32'(gen_reset), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("ovf_x0_%0d", k), 32'(out_x0), 32'(16'hA000 + 16'(7 + k)));
            chk($sformatf("ovf_x1_%0d", k), 32'(out_x1), 32'(16'h5000 + 16'(7 + k)));
            out_ready = 1'b1;
            step();
        end
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_valid_end", 32'(out_valid), 32'd0);
        step();
        chk("ovf_done_low", 32'(done), 32'd0);

        // Zero-length run
        start = 1'b1; num_samples = 16'd0;
        step();
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_gen_reset", 32'(gen_reset), 32'd1);
        step();
        chk("zero_done_low", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);

        // Seed writes in IDLE
        seed_we = 1'b1; seed_sel = 3'd2; seed_in = 32'h12345678;
        step();
        chk("seed_s3", s3, 32'h12345678);
        seed_sel = 3'd6; seed_in = 32'hDEADBEEF;
        step();
        seed_we = 1'b0;
        chk("seed6_s1", s1, 32'hFFFFFFFF);
        chk("seed6_s3", s3, 32'h12345678);
        chk("seed6_s6", s6, 32'hFDEAFDEA);

        // Writes while busy are ignored, then reset mid-RUN with pairs queued
        out_ready = 1'b0;
        start = 1'b1; num_samples = 16'd8; set_gen(0);
        step();
        start = 1'b0;
        seed_we = 1'b1; seed_sel = 3'd0; seed_in = 32'h0;
        for (int c = 2; c <= 9; c++) begin
            step();
            set_gen(c);
        end
        chk("busy_wr_s1", s1, 32'hFFFFFFFF);
        chk("midrun_valid", 32'(out_valid), 32'd1);
        chk("midrun_gen_reset", 32'(gen_reset), 32'd0);
        seed_we = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_defaults("mid_rst");
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_x0", 32'(out_x0), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gen_reset", 32'(gen_reset), 32'd1);
        chk("mid_rst_ovf", 32'(overflow_cnt), 32'd0);

        // Fresh 2-pair run after reset
        out_ready = 1'b1;
        start = 1'b1; num_samples = 16'd2; set_gen(0);
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            set_gen(c);
            if (c == 8 || c == 9) begin
                chk($sformatf("fresh_x0_c%0d", c), 32'(out_x0), 32'(16'hA000 + 16'(c - 1)));
                chk($sformatf("fresh_valid_c%0d", c), 32'(out_valid), 32'd1);
            end
        end
        chk("fresh_done", 32'(done), 32'd1);
        chk("fresh_ovf", 32'(overflow_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
